// File: rtl/cnu_c2v_gen.sv
// cnu_c2v_gen: offset min-sum check-node output stage.
// Delays signs/valid to line up with the min-finder, then emits 32 two's-complement c2v messages per row.
module cnu_c2v_gen #(
    parameter int W    = 6,
    parameter int WC   = 32,
    parameter int LAT  = 5,
    parameter int BETA = 1,
    parameter int IW   = $clog2(WC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [WC-1:0]   in_sign,
    input  logic [W-2:0]    min1,
    input  logic [W-2:0]    min2,
    input  logic [IW-1:0]   idx,
    output logic            out_valid,
    output logic [WC*W-1:0] c2v,
    output logic            parity
);
    localparam logic [W-2:0] B = (W-1)'(BETA);

    logic [LAT-1:0] dv;
    logic [WC-1:0]  ds [LAT];
    logic           v_a, par_a;
    logic [WC-1:0]  sign_a;
    logic [W-2:0]   m1_a, m2_a, m1o, m2o;
    logic [IW-1:0]  idx_a;
    logic [WC*W-1:0] nxt;

    // Free-running delay line: shifts every cycle to track the min-finder pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                dv[i] <= 1'b0;
                ds[i] <= '0;
            end
        end else begin
            dv[0] <= in_valid;
            ds[0] <= in_sign;
            for (int i = 1; i < LAT; i++) begin
                dv[i] <= dv[i-1];
                ds[i] <= ds[i-1];
            end
        end
    end

    always_comb begin
        m1o = (min1 > B) ? min1 - B : '0;
        m2o = (min2 > B) ? min2 - B : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_a    <= 1'b0;
            par_a  <= 1'b0;
            sign_a <= '0;
            m1_a   <= '0;
            m2_a   <= '0;
            idx_a  <= '0;
        end else begin
            v_a    <= dv[LAT-1];
            par_a  <= ^ds[LAT-1];
            sign_a <= ds[LAT-1];
            m1_a   <= m1o;
            m2_a   <= m2o;
            idx_a  <= idx;
        end
    end

    // Negating a zero magnitude yields all-zeros, so no -0 can appear.
    for (genvar j = 0; j < WC; j++) begin : g_msg
        logic [W-1:0] mag;
        assign mag = {1'b0, (idx_a == IW'(j)) ? m2_a : m1_a};
        assign nxt[j*W +: W] = (par_a ^ sign_a[j]) ? -mag : mag;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            c2v       <= '0;
            parity    <= 1'b0;
        end else begin
            out_valid <= v_a;
            c2v       <= nxt;
            parity    <= par_a;
        end
    end
endmodule

// File: tb/tb_cnu_c2v_gen.sv
// tb_cnu_c2v_gen: drives rows with min1/min2/idx offset by LAT cycles, as the min-finder would,
// and compares two instances (BETA=1 and BETA=0) against an arithmetic reference.
module tb_cnu_c2v_gen;
    localparam int W = 6, WC = 32, LAT = 5, N = 95;

    logic clk = 1'b0;
    logic rst, in_valid, parity1, parity0, ov1, ov0;
    logic [WC-1:0] in_sign;
    logic [W-2:0] min1, min2;
    logic [4:0] idx;
    logic [WC*W-1:0] c1, c0;

    int checks = 0, errors = 0;
    logic v [N], rl [N];
    logic [WC-1:0] sg [N];
    int a1 [N], a2 [N], ix [N];

    always #5 clk = ~clk;

    cnu_c2v_gen #(.W(W), .WC(WC), .LAT(LAT), .BETA(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sign(in_sign), .min1(min1), .min2(min2),
        .idx(idx), .out_valid(ov1), .c2v(c1), .parity(parity1));

    cnu_c2v_gen #(.W(W), .WC(WC), .LAT(LAT), .BETA(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sign(in_sign), .min1(min1), .min2(min2),
        .idx(idx), .out_valid(ov0), .c2v(c0), .parity(parity0));

    task automatic chk(input string tag, input logic [WC*W-1:0] obs, input logic [WC*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WC*W-1:0] model(input logic [WC-1:0] s, input int m1, input int m2,
                                               input int id, input int beta);
        logic [WC*W-1:0] r;
        int p;
        p = $countones(s) % 2;
        r = '0;
        for (int j = 0; j < WC; j++) begin
            int mag, val;
            mag = (j == id ? m2 : m1) - beta;
            if (mag < 0) mag = 0;
            val = ((p != 0) != s[j]) ? -mag : mag;
            r[j*W +: W] = val[W-1:0];
        end
        return r;
    endfunction

    // A row presented in cycle k-LAT-2 emerges in cycle k unless a reset edge fell in between.
    function automatic logic exp_valid(input int k);
        if (k < LAT + 2) return 1'b0;
        for (int i = k - LAT - 2; i < k; i++) if (rl[i]) return 1'b0;
        return v[k-LAT-2];
    endfunction

    initial begin
        for (int t = 0; t < N; t++) begin
            v[t] = 1'b0;
            rl[t] = 1'b0;
            sg[t] = $urandom;
            a1[t] = $urandom_range(0, 31);
            a2[t] = $urandom_range(a1[t], 31);
            ix[t] = $urandom_range(0, 31);
        end
        for (int t = 0; t < 3; t++) rl[t] = 1'b1;
        v[3] = 1; sg[3] = '0; a1[3] = 3; a2[3] = 7; ix[3] = 4;
        v[4] = 1; sg[4] = 32'h1; a1[4] = 3; a2[4] = 7; ix[4] = 4;
        v[5] = 1; sg[5] = '1; a1[5] = 1; a2[5] = 0; ix[5] = 31;
        v[6] = 1; sg[6] = 32'h20; a1[6] = 31; a2[6] = 31; ix[6] = 0;
        v[7] = 1; a1[7] = 5; a2[7] = 5; ix[7] = 0;
        for (int t = 10; t < 20; t++) v[t] = 1;
        for (int t = 21; t < 24; t++) v[t] = 1;
        for (int t = 30; t < 34; t++) v[t] = 1;
        rl[35] = 1;
        v[36] = 1;
        for (int t = 45; t < 80; t++) v[t] = 1'($urandom_range(0, 1));

        for (int c = 0; c < N; c++) begin
            int k, t;
            logic ev;
            rst = !rl[c];
            in_valid = v[c];
            in_sign = sg[c];
            min1 = (c >= LAT) ? 5'(a1[c-LAT]) : 5'($urandom);
            min2 = (c >= LAT) ? 5'(a2[c-LAT]) : 5'($urandom);
            idx  = (c >= LAT) ? 5'(ix[c-LAT]) : 5'($urandom);
            @(posedge clk);
            #2;
            k = c + 1;
            ev = exp_valid(k);
            chk($sformatf("valid_b1@%0d", k), {191'b0, ov1}, {191'b0, ev});
            chk($sformatf("valid_b0@%0d", k), {191'b0, ov0}, {191'b0, ev});
            if (ev) begin
                t = k - LAT - 2;
                chk($sformatf("c2v_b1@%0d", k), c1, model(sg[t], a1[t], a2[t], ix[t], 1));
                chk($sformatf("c2v_b0@%0d", k), c0, model(sg[t], a1[t], a2[t], ix[t], 0));
                chk($sformatf("par_b1@%0d", k), {191'b0, parity1}, 192'($countones(sg[t]) % 2));
                chk($sformatf("par_b0@%0d", k), {191'b0, parity0}, 192'($countones(sg[t]) % 2));
            end
            if (rl[c]) begin
                chk($sformatf("rst_c2v@%0d", k), c1 | c0, '0);
                chk($sformatf("rst_par@%0d", k), {190'b0, parity1, parity0}, '0);
            end
            if (k == 10) begin
                chk("single_c4", {186'b0, c1[4*W +: W]}, 192'd6);
                chk("single_c0", {186'b0, c1[0 +: W]}, 192'd2);
            end
            if (k == 11) begin
                chk("sign_c4", {186'b0, c1[4*W +: W]}, {186'b0, 6'b111010});
                chk("sign_c0", {186'b0, c1[0 +: W]}, 192'd2);
                chk("sign_c1", {186'b0, c1[W +: W]}, {186'b0, 6'b111110});
                chk("sign_par", {191'b0, parity1}, 192'd1);
            end
            if (k == 12) chk("sat_all", c1, '0);
            if (k == 13) begin
                chk("max_c5", {186'b0, c0[5*W +: W]}, 192'd31);
                chk("max_c0", {186'b0, c0[0 +: W]}, {186'b0, 6'b100001});
                chk("max_par", {191'b0, parity0}, 192'd1);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnu_c2v_gen.md
# cnu_c2v_gen

Check-node output stage of the min-sum LDPC decoder. It sits directly downstream of the 32-input pipelined two-minimum finder. It takes that finder's registered min1, min2 and 5-bit argmin index, applies offset correction, and re-attaches the sign information, which it delays internally to stay aligned. It emits all 32 check-to-variable messages in two's complement, one check row per cycle, fully pipelined.

## Interface
- W, 6, message width in bits; magnitudes are W-1 bits.
- Wc, 32, check-node degree; must equal 2^(width of idx).
- LAT, 5, cycles from x/in_sign presentation at the min-finder input to valid min1/min2/idx at this block's input. Must equal the min-finder pipeline depth.
- BETA, 1, offset subtracted from both magnitudes (offset min-sum).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  high in the cycle a new row's magnitudes x are applied to the min-finder.
- in_sign  in  Wc  sign bits of the 32 variable-to-check messages, applied in the same cycle as x; bit j belongs to input j.
- min1  in  W-1  smallest magnitude, from the min-finder.
- min2  in  W-1  second-smallest magnitude, from the min-finder.
- idx  in  5  position of min1, from the min-finder.
- out_valid  out  1  c2v and parity hold a valid row.
- c2v  out  Wc*W  32 messages; message j occupies bits [j*W+W-1 : j*W], two's complement.
- parity  out  1  XOR of all 32 in_sign bits of the row.

## Operation
- **Sign/valid delay line:** LAT-deep shift register of {in_valid, in_sign}.
  - Shifts every cycle, whether or not in_valid is high, because the min-finder is free-running.
  - Stage LAT is time-aligned with min1/min2/idx.
- **Stage A (registered):**
  - m1o = (min1 > BETA) ? min1 - BETA : 0
  - m2o = (min2 > BETA) ? min2 - BETA : 0
  - par = XOR-reduce of the delayed sign word.
  - Register m1o, m2o, idx, par, the sign word and the valid bit.
- **Stage B (registered):** for each j in 0..Wc-1:
  - mag_j = (j == idx) ? m2o : m1o
  - s_j = par ^ sign[j]
  - c2v_j = s_j ? -{0,mag_j} : {0,mag_j}, W bits.
  - A negative zero encodes as all-zeros.
  - parity <= par; out_valid <= delayed valid.
- **Arithmetic:**
  - Magnitude range is 0..2^(W-1)-1, so c2v_j lies in -31..+31 for W=6.
  - -32 is never produced.
  - No rounding or scaling beyond BETA.
- No backpressure. The consumer must accept one row per cycle whenever out_valid is high.
- There is no FSM beyond the valid pipeline. Bubbles (in_valid=0) propagate unchanged.
- When out_valid=0, c2v and parity still update from the pipeline data. Consumers must qualify them with out_valid.

## Timing
- Latency from in_valid high to out_valid high is LAT+2 cycles (7 at defaults).
- Throughput is one row per clock. Back-to-back rows need no gap.
- **Reset:** while rst=0 at a clock edge, the following clear to 0: all delay-line stages, all Stage A registers, out_valid, c2v and parity.
- **Reset mid-operation:**
  - Every in-flight row is discarded.
  - Outputs are 0 from the first edge at which rst=0 is sampled.
  - After rst returns high, out_valid stays 0 until a row presented after reset has traversed LAT+2 cycles.
- **min1 == min2:** all 32 magnitudes are equal; the idx position takes m2o, which here equals m1o.
- **min1 <= BETA:** every message except the one at idx has magnitude 0. It encodes as 0 regardless of sign.
- **idx = Wc-1 and idx = 0:** the boundary positions must select m2o correctly; there is no wrap-around or aliasing.

## Test plan
- **Single row:**
  - Stimulus: min1=3, min2=7, idx=4, in_sign=0, BETA=1.
  - Required: at cycle LAT+2, out_valid=1; c2v_4=+6; every other c2v_j=+2; parity=0.
- **Sign handling:**
  - Stimulus: same magnitudes as the single-row case; in_sign bit0=1 only.
  - Required: parity=1; c2v_0=+2 (its own sign cancels); c2v_4=-6 (encoding 6'b111010); every other c2v_j=-2.
- **Saturation:**
  - Stimulus: min1=1, min2=0, idx=31, all signs 1.
  - Required: parity=0; every c2v_j=0 (c2v_31 = sat(0-1) = 0); no -0 encoding appears.
- **Throughput and bubbles:**
  - Stimulus: 10 back-to-back rows with random data, one idle cycle, then 3 more rows.
  - Required: out_valid shows exactly the same 10-1-3 pattern delayed by LAT+2; every row matches the reference model.
- **Reset mid-flight:**
  - Stimulus: assert rst=0 for 1 cycle while 4 rows are in flight.
  - Required: all outputs are 0 on the next edge; none of the 4 rows ever appears; a row issued after reset appears LAT+2 cycles later.
- **Maximum magnitude:**
  - Stimulus: min1=31, min2=31, idx=0, BETA=0, all signs 0 except bit5.
  - Required: parity=1; c2v_5=+31; every other c2v_j=-31 (6'b100001).
